// File: rtl/cpu_structs_pkg.sv
// Shared types and line geometry for the L1 <-> system-memory arbiter.
package cpu_structs_pkg;

  localparam int PC_SZ      = 32;
  localparam int CL_SZ      = 5;
  localparam int ARB_CL_LEN = 1 << CL_SZ;
  localparam int ARB_LA_W   = PC_SZ - CL_SZ;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    MEM_REQ,
    MEM_RD,
    ACK
  } arb_state_e;

  typedef enum logic {
    SRC_IC,
    SRC_DC
  } arb_src_e;

  // Sized by the package geometry; override top parameters only together with these.
  typedef struct packed {
    logic                    rw;
    logic [ARB_LA_W-1:0]     addr;
    logic [ARB_CL_LEN*8-1:0] wr_data;
  } arb_mem_req_t;

endpackage

// File: rtl/arb_pick.sv
// Winner select for the arbiter plus the last_grant register, which also names the current owner.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise the I$ always wins.
module arb_pick
  import cpu_structs_pkg::*;
(
  input  logic     clk_in,
  input  logic     reset_in,
  input  logic     ic_valid,
  input  logic     dc_valid,
  input  logic     take,
  output arb_src_e last_grant
);

  arb_src_e winner;
  logic     prefer_ic;

`ifdef ARB_ROUND_ROBIN_EN
  assign prefer_ic = (last_grant == SRC_DC);
`else
  assign prefer_ic = 1'b1;
`endif

  always_comb begin
    winner = SRC_DC;
    if (ic_valid && dc_valid) winner = prefer_ic ? SRC_IC : SRC_DC;
    else if (ic_valid)        winner = SRC_IC;
  end

  // Loaded as the grant is taken, so it holds the owner for the whole transaction.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)  last_grant <= SRC_DC;
    else if (take) last_grant <= winner;
  end

endmodule

// File: rtl/l1_sysmem_arbiter.sv
// Shares one system-memory port between I$ line fills and D$ fills/write-backs, one line at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed I$ priority.
module l1_sysmem_arbiter
  import cpu_structs_pkg::*;
#(
  parameter int CL_LEN = ARB_CL_LEN,
  parameter int LA_W   = ARB_LA_W
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                ic_req_valid,
  input  logic [LA_W-1:0]     ic_req_addr,
  output logic                ic_req_rdy,
  output logic                ic_ack_valid,
  output logic [CL_LEN*8-1:0] ic_ack_data,
  input  logic                ic_ack_rdy,
  input  logic                dc_req_valid,
  input  logic                dc_req_rw,
  input  logic [LA_W-1:0]     dc_req_addr,
  input  logic [CL_LEN*8-1:0] dc_req_wr_data,
  output logic                dc_req_rdy,
  output logic                dc_ack_valid,
  output logic [CL_LEN*8-1:0] dc_ack_data,
  input  logic                dc_ack_rdy,
  output logic                mem_req_valid,
  output logic                mem_req_rw,
  output logic [LA_W-1:0]     mem_req_addr,
  output logic [CL_LEN*8-1:0] mem_req_wr_data,
  input  logic                mem_req_rdy,
  input  logic                mem_rd_valid,
  input  logic [CL_LEN*8-1:0] mem_rd_data
);

  arb_state_e          state_q, state_d;
  arb_src_e            owner;
  arb_mem_req_t        req_q, req_sel;
  logic [CL_LEN*8-1:0] ic_ack_data_q, dc_ack_data_q;
  logic                take;

  assign take = (state_q == IDLE) && (ic_req_valid || dc_req_valid);

  arb_pick u_pick (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .ic_valid   (ic_req_valid),
    .dc_valid   (dc_req_valid),
    .take       (take),
    .last_grant (owner)
  );

  // I$ traffic is always a read; its write-data field is unused.
  always_comb begin
    req_sel = '{rw: 1'b1, addr: ic_req_addr, wr_data: '0};
    if (owner == SRC_DC) req_sel = '{rw: dc_req_rw, addr: dc_req_addr, wr_data: dc_req_wr_data};
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ic_req_rdy    = 1'b0;
    dc_req_rdy    = 1'b0;
    mem_req_valid = 1'b0;
    ic_ack_valid  = 1'b0;
    dc_ack_valid  = 1'b0;
    unique case (state_q)
      IDLE: if (take) state_d = ACCEPT;
      ACCEPT: begin
        ic_req_rdy = (owner == SRC_IC);
        dc_req_rdy = (owner == SRC_DC);
        state_d    = MEM_REQ;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_rdy) state_d = req_q.rw ? MEM_RD : IDLE;
      end
      MEM_RD: if (mem_rd_valid) state_d = ACK;
      ACK: begin
        ic_ack_valid = (owner == SRC_IC);
        dc_ack_valid = (owner == SRC_DC);
        if ((owner == SRC_IC) ? ic_ack_rdy : dc_ack_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch and ack lines; all cleared on reset so every output starts at zero.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      req_q         <= '0;
      ic_ack_data_q <= '0;
      dc_ack_data_q <= '0;
    end else begin
      if (state_q == ACCEPT) req_q <= req_sel;
      if (state_q == MEM_RD && mem_rd_valid) begin
        if (owner == SRC_IC) ic_ack_data_q <= mem_rd_data;
        else                 dc_ack_data_q <= mem_rd_data;
      end
    end
  end

  assign mem_req_rw      = req_q.rw;
  assign mem_req_addr    = req_q.addr;
  assign mem_req_wr_data = req_q.wr_data;
  assign ic_ack_data     = ic_ack_data_q;
  assign dc_ack_data     = dc_ack_data_q;

  // A requester must keep req_valid up until it has been handed req_rdy.
  ic_hold_a: assert property (@(posedge clk_in) disable iff (reset_in)
    ic_req_valid && !ic_req_rdy |=> ic_req_valid);
  dc_hold_a: assert property (@(posedge clk_in) disable iff (reset_in)
    dc_req_valid && !dc_req_rdy |=> dc_req_valid);

endmodule

// File: tb/tb_l1_sysmem_arbiter.sv
// Directed scoreboard bench for l1_sysmem_arbiter (honours ARB_ROUND_ROBIN_EN when defined).
module tb_l1_sysmem_arbiter;
  import cpu_structs_pkg::*;

  localparam int CL_LEN = ARB_CL_LEN;
  localparam int LA_W   = ARB_LA_W;
  localparam int DW     = CL_LEN * 8;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic            ic_req_valid, ic_req_rdy, ic_ack_valid, ic_ack_rdy;
  logic [LA_W-1:0] ic_req_addr;
  logic [DW-1:0]   ic_ack_data;
  logic            dc_req_valid, dc_req_rw, dc_req_rdy, dc_ack_valid, dc_ack_rdy;
  logic [LA_W-1:0] dc_req_addr;
  logic [DW-1:0]   dc_req_wr_data, dc_ack_data;
  logic            mem_req_valid, mem_req_rw, mem_req_rdy, mem_rd_valid;
  logic [LA_W-1:0] mem_req_addr;
  logic [DW-1:0]   mem_req_wr_data, mem_rd_data;

  always #5 clk_in = ~clk_in;

  l1_sysmem_arbiter dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .ic_req_valid    (ic_req_valid),
    .ic_req_addr     (ic_req_addr),
    .ic_req_rdy      (ic_req_rdy),
    .ic_ack_valid    (ic_ack_valid),
    .ic_ack_data     (ic_ack_data),
    .ic_ack_rdy      (ic_ack_rdy),
    .dc_req_valid    (dc_req_valid),
    .dc_req_rw       (dc_req_rw),
    .dc_req_addr     (dc_req_addr),
    .dc_req_wr_data  (dc_req_wr_data),
    .dc_req_rdy      (dc_req_rdy),
    .dc_ack_valid    (dc_ack_valid),
    .dc_ack_data     (dc_ack_data),
    .dc_ack_rdy      (dc_ack_rdy),
    .mem_req_valid   (mem_req_valid),
    .mem_req_rw      (mem_req_rw),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wr_data (mem_req_wr_data),
    .mem_req_rdy     (mem_req_rdy),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data)
  );

  typedef struct {
    logic            rw;
    logic [LA_W-1:0] addr;
    logic [DW-1:0]   wr_data;
  } mem_exp_t;

  mem_exp_t      ic_mem_q[$];
  mem_exp_t      dc_mem_q[$];
  logic [DW-1:0] ack_q[$];
  logic [DW-1:0] last_ic, last_dc;
  arb_src_e      model_last;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/ic_req_rdy"},   DW'(ic_req_rdy),     '0);
    chk({tag, "/dc_req_rdy"},   DW'(dc_req_rdy),     '0);
    chk({tag, "/ic_ack_valid"}, DW'(ic_ack_valid),   '0);
    chk({tag, "/dc_ack_valid"}, DW'(dc_ack_valid),   '0);
    chk({tag, "/ic_ack_data"},  ic_ack_data,         '0);
    chk({tag, "/dc_ack_data"},  dc_ack_data,         '0);
    chk({tag, "/mem_valid"},    DW'(mem_req_valid),  '0);
    chk({tag, "/mem_rw"},       DW'(mem_req_rw),     '0);
    chk({tag, "/mem_addr"},     DW'(mem_req_addr),   '0);
    chk({tag, "/mem_wdata"},    mem_req_wr_data,     '0);
  endtask

  task automatic drive_req(input arb_src_e src, input logic rw, input logic [LA_W-1:0] addr,
                           input logic [DW-1:0] wd);
    mem_exp_t e;
    if (src == SRC_IC) begin
      ic_req_valid = 1'b1;
      ic_req_addr  = addr;
      e = '{rw: 1'b1, addr: addr, wr_data: '0};
      ic_mem_q.push_back(e);
    end else begin
      dc_req_valid   = 1'b1;
      dc_req_rw      = rw;
      dc_req_addr    = addr;
      dc_req_wr_data = wd;
      e = '{rw: rw, addr: addr, wr_data: wd};
      dc_mem_q.push_back(e);
    end
  endtask

  // Entered at the negedge of the expected ACCEPT cycle; leaves at a negedge in IDLE.
  task automatic run_txn(input string tag, input arb_src_e src, input logic [DW-1:0] rdata,
                         input int mstall, input int astall);
    mem_exp_t      e;
    logic [DW-1:0] a;
    if (src == SRC_IC) e = ic_mem_q.pop_front();
    else               e = dc_mem_q.pop_front();
    model_last = src;
    chk({tag, "/ic_req_rdy"}, DW'(ic_req_rdy), DW'(src == SRC_IC));
    chk({tag, "/dc_req_rdy"}, DW'(dc_req_rdy), DW'(src == SRC_DC));
    tick();
    if (src == SRC_IC) ic_req_valid = 1'b0;
    else               dc_req_valid = 1'b0;
    for (int k = 0; k <= mstall; k++) begin
      chk({tag, "/mem_valid"}, DW'(mem_req_valid), DW'(1'b1));
      chk({tag, "/mem_rw"},    DW'(mem_req_rw),    DW'(e.rw));
      chk({tag, "/mem_addr"},  DW'(mem_req_addr),  DW'(e.addr));
      if (!e.rw) chk({tag, "/mem_wdata"}, mem_req_wr_data, e.wr_data);
      mem_req_rdy = (k == mstall);
      tick();
    end
    mem_req_rdy = 1'b0;
    chk({tag, "/mem_valid_drop"}, DW'(mem_req_valid), '0);
    if (e.rw) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = rdata;
      ack_q.push_back(rdata);
      tick();
      mem_rd_valid = 1'b0;
      mem_rd_data  = ~rdata;
      a = ack_q.pop_front();
      for (int k = 0; k <= astall; k++) begin
        chk({tag, "/ic_ack_valid"}, DW'(ic_ack_valid), DW'(src == SRC_IC));
        chk({tag, "/dc_ack_valid"}, DW'(dc_ack_valid), DW'(src == SRC_DC));
        chk({tag, "/ack_data"}, (src == SRC_IC) ? ic_ack_data : dc_ack_data, a);
        if (src == SRC_IC) ic_ack_rdy = (k == astall);
        else               dc_ack_rdy = (k == astall);
        tick();
      end
      ic_ack_rdy = 1'b0;
      dc_ack_rdy = 1'b0;
      chk({tag, "/ack_drop"}, DW'(ic_ack_valid | dc_ack_valid), '0);
      if (src == SRC_IC) last_ic = a;
      else               last_dc = a;
    end else begin
      chk({tag, "/no_ack"}, DW'(ic_ack_valid | dc_ack_valid), '0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] line1, line;
    arb_src_e      w;
    ic_req_valid = 0; ic_req_addr = '0; ic_ack_rdy = 0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_wr_data = '0; dc_ack_rdy = 0;
    mem_req_rdy = 0; mem_rd_valid = 0; mem_rd_data = '0;
    last_ic = '0; last_dc = '0; model_last = SRC_DC;
    reset_in = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    reset_in = 1'b0;
    tick();

    // I$ fill at minimum latency
    for (int p = 0; p < CL_LEN; p++) line1[p*8 +: 8] = 8'(p);
    drive_req(SRC_IC, 1'b1, LA_W'('h10), '0);
    tick();
    run_txn("t1", SRC_IC, line1, 0, 0);

    // D$ write-back; the next test's 1-cycle grant shows it is back in IDLE
    drive_req(SRC_DC, 1'b0, LA_W'('h20), {CL_LEN{8'hA5}});
    tick();
    run_txn("t2", SRC_DC, '0, 0, 0);

    // both requesters contending for four rounds
    for (int r = 0; r < 4; r++) begin
      if (!ic_req_valid) drive_req(SRC_IC, 1'b1, LA_W'('h100 + r), '0);
      if (!dc_req_valid) drive_req(SRC_DC, 1'b1, LA_W'('h200 + r), '0);
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      w = (model_last == SRC_DC) ? SRC_IC : SRC_DC;
`else
      w = SRC_IC;
`endif
      line = {(DW/32){32'hC0DE_0000 + 32'(r)}};
      run_txn($sformatf("t3r%0d", r), w, line, 0, 0);
    end
    if (ic_req_valid) begin
      tick();
      run_txn("t3ic", SRC_IC, {(DW/32){32'h1C1C_0001}}, 0, 0);
    end
    if (dc_req_valid) begin
      tick();
      run_txn("t3dc", SRC_DC, {(DW/32){32'hDCDC_0002}}, 0, 0);
    end

    // backpressure on both the memory request and the ack
    drive_req(SRC_IC, 1'b1, LA_W'('h300), '0);
    tick();
    run_txn("t4ic", SRC_IC, {(DW/32){32'h0BAD_F00D}}, 5, 3);
    drive_req(SRC_DC, 1'b1, LA_W'('h301), '0);
    tick();
    run_txn("t4dc", SRC_DC, {(DW/32){32'h1234_5678}}, 2, 2);

    // reset while waiting for read data, then a re-issued fill
    drive_req(SRC_IC, 1'b1, LA_W'('h400), '0);
    tick();
    chk("t5/ic_req_rdy", DW'(ic_req_rdy), DW'(1'b1));
    tick();
    ic_req_valid = 1'b0;
    mem_req_rdy  = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    void'(ic_mem_q.pop_front());
    chk("t5/mem_addr_pre", DW'(mem_req_addr), DW'(LA_W'('h400)));
    #2 reset_in = 1'b1;
    #1 chk_all_zero("t5rst");
    #1 reset_in = 1'b0;
    model_last = SRC_DC;
    last_ic = '0;
    last_dc = '0;
    tick();
    drive_req(SRC_IC, 1'b1, LA_W'('h400), '0);
    tick();
    run_txn("t5re", SRC_IC, {(DW/32){32'h5A5A_0400}}, 0, 0);

    // stray read data while idle
    mem_rd_valid = 1'b1;
    mem_rd_data  = {(DW/32){32'hFEED_BEEF}};
    tick();
    mem_rd_valid = 1'b0;
    chk("t6/ic_ack_valid", DW'(ic_ack_valid), '0);
    chk("t6/dc_ack_valid", DW'(dc_ack_valid), '0);
    chk("t6/ic_ack_data",  ic_ack_data, last_ic);
    chk("t6/dc_ack_data",  dc_ack_data, last_dc);
    tick();
    chk("t6/ack_valid_late", DW'(ic_ack_valid | dc_ack_valid), '0);
    chk("t6/mem_valid", DW'(mem_req_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
